// File: rtl/tm1638_pkg.sv
// Shared constants and state types for the TM1638 command sequencer.
package tm1638_pkg;

   // TM1638 command bytes
   localparam logic [7:0] CMD_DATA_FIXED = 8'h44;
   localparam logic [7:0] CMD_READ_KEYS  = 8'h42;
   localparam logic [7:0] CMD_ADDR_BASE  = 8'hC0;
   localparam logic [7:0] CMD_DISP_CTRL  = 8'h80;

   // Flag positions inside the 18-bit SPI request word
   localparam int unsigned SPI_RD_FLAG  = 17;
   localparam int unsigned SPI_HAS_DATA = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MODE,
      S_DIGITS,
      S_CTRL,
      S_SCAN
   } top_state_t;

   typedef enum logic [1:0] {
      T_IDLE,
      T_ISSUE,
      T_WAIT_ACK,
      T_WAIT_DONE
   } txn_state_t;

endpackage

// File: rtl/tm1638_spi_txn.sv
// One request/busy handshake with the SPI engine; pulses done when it finishes.
module tm1638_spi_txn
   import tm1638_pkg::*;
(
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic        start,
   input  logic [17:0] payload,
   input  logic        i_Spi_Busy,
   output logic        done,
   output logic        o_Spi_Data_Ready,
   output logic [17:0] o_Spi_Data
);

   txn_state_t state;

   // Handshake FSM; start is a level, so the done cycle itself is not allowed
   // to launch, giving the caller one edge to present the next payload.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state            <= T_IDLE;
         done             <= 1'b0;
         o_Spi_Data_Ready <= 1'b0;
         o_Spi_Data       <= '0;
      end else begin
         done             <= 1'b0;
         o_Spi_Data_Ready <= 1'b0;
         case (state)
            T_IDLE: begin
               if (start && !done && !i_Spi_Busy) begin
                  o_Spi_Data       <= payload;
                  o_Spi_Data_Ready <= 1'b1;
                  state            <= T_ISSUE;
               end
            end
            T_ISSUE: begin
               state <= T_WAIT_ACK;
            end
            T_WAIT_ACK: begin
               if (i_Spi_Busy) state <= T_WAIT_DONE;
            end
            T_WAIT_DONE: begin
               if (!i_Spi_Busy) begin
                  done  <= 1'b1;
                  state <= T_IDLE;
               end
            end
            default: state <= T_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/tm1638_ctrl.sv
// TM1638 sequencer: display refresh (mode, 16 digits, control) and periodic key scan
// sharing one SPI transaction engine.
module tm1638_ctrl
   import tm1638_pkg::*;
#(
   parameter int unsigned SCAN_PERIOD = 250000,
   parameter int unsigned READ_WIDTH  = 32
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic [127:0]          i_Disp_Data,
   input  logic [2:0]            i_Brightness,
   input  logic                  i_Disp_On,
   input  logic                  i_Update,
   output logic                  o_Busy,
   output logic [READ_WIDTH-1:0] o_Keys,
   output logic                  o_Keys_Valid,
   output logic                  o_Keys_Changed,
   output logic                  o_Spi_Data_Ready,
   output logic [17:0]           o_Spi_Data,
   input  logic                  i_Spi_Busy,
   input  logic [READ_WIDTH-1:0] i_Spi_Rd_Data
);

   localparam int unsigned CW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_PERIOD - 1);

   top_state_t     state;
   logic [3:0]     addr;
   logic           refresh_pending;
   logic           scan_pending;
   logic [CW-1:0]  scan_cnt;
   logic           scan_tick;
   logic [127:0]   shadow_data;
   logic [2:0]     shadow_bri;
   logic           shadow_on;
   logic [17:0]    payload;
   logic           txn_start;
   logic           txn_done;

   assign scan_tick = (scan_cnt == SCAN_LAST);
   assign txn_start = (state != S_IDLE);
   assign o_Busy    = (state != S_IDLE);

   // Request word for the transaction belonging to the current state
   always_comb begin
      payload = '0;
      case (state)
         S_MODE: payload[7:0] = CMD_DATA_FIXED;
         S_DIGITS: begin
            payload[SPI_HAS_DATA] = 1'b1;
            payload[15:8]         = shadow_data[{addr, 3'b000} +: 8];
            payload[7:0]          = CMD_ADDR_BASE | {4'h0, addr};
         end
         S_CTRL: payload[7:0] = CMD_DISP_CTRL | {4'h0, shadow_on, shadow_bri};
         S_SCAN: begin
            payload[SPI_RD_FLAG] = 1'b1;
            payload[7:0]         = CMD_READ_KEYS;
         end
         default: payload = '0;
      endcase
   end

   // Sequencer FSM, scan timer and request flags; a flag taken in S_IDLE is
   // cleared with priority over a same-cycle set (the snapshot/scan covers it).
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state           <= S_IDLE;
         addr            <= '0;
         refresh_pending <= 1'b1;
         scan_pending    <= 1'b0;
         scan_cnt        <= '0;
         shadow_data     <= '0;
         shadow_bri      <= '0;
         shadow_on       <= 1'b0;
         o_Keys          <= '0;
         o_Keys_Valid    <= 1'b0;
         o_Keys_Changed  <= 1'b0;
      end else begin
         o_Keys_Valid   <= 1'b0;
         o_Keys_Changed <= 1'b0;
         scan_cnt       <= scan_tick ? '0 : scan_cnt + 1'b1;
         if (scan_tick) scan_pending <= 1'b1;
         if (i_Update) refresh_pending <= 1'b1;
         case (state)
            S_IDLE: begin
               if (refresh_pending) begin
                  refresh_pending <= 1'b0;
                  shadow_data     <= i_Disp_Data;
                  shadow_bri      <= i_Brightness;
                  shadow_on       <= i_Disp_On;
                  state           <= S_MODE;
               end else if (scan_pending) begin
                  scan_pending <= 1'b0;
                  state        <= S_SCAN;
               end
            end
            S_MODE: begin
               if (txn_done) begin
                  addr  <= '0;
                  state <= S_DIGITS;
               end
            end
            S_DIGITS: begin
               if (txn_done) begin
                  if (addr == 4'd15) state <= S_CTRL;
                  else               addr  <= addr + 1'b1;
               end
            end
            S_CTRL: begin
               if (txn_done) state <= S_IDLE;
            end
            S_SCAN: begin
               if (txn_done) begin
                  o_Keys         <= i_Spi_Rd_Data;
                  o_Keys_Valid   <= 1'b1;
                  o_Keys_Changed <= (i_Spi_Rd_Data != o_Keys);
                  state          <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   tm1638_spi_txn u_txn (
      .i_Clk            (i_Clk),
      .i_Rst            (i_Rst),
      .start            (txn_start),
      .payload          (payload),
      .i_Spi_Busy       (i_Spi_Busy),
      .done             (txn_done),
      .o_Spi_Data_Ready (o_Spi_Data_Ready),
      .o_Spi_Data       (o_Spi_Data)
   );

endmodule

// File: tb/tb_tm1638_ctrl.sv
// Directed bench for tm1638_ctrl with a 20-cycle-busy SPI engine model.
module tb_tm1638_ctrl;

   localparam int unsigned SP = 100;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] disp_data;
   logic [2:0]   bri;
   logic         disp_on;
   logic         upd;
   logic         busy;
   logic [31:0]  keys;
   logic         keys_valid;
   logic         keys_changed;
   logic         spi_ready;
   logic [17:0]  spi_data;
   logic         spi_busy = 1'b0;
   logic [31:0]  spi_rd = '0;

   logic [31:0]  key_val;
   logic [17:0]  log_q [0:511];
   int           logn = 0;
   int           m_cnt = 0;
   int           cyc = 0;
   int           ntick = 0;
   int           checks = 0;
   int           errors = 0;

   logic [127:0] old_img;
   logic [127:0] new_img;
   int           base;
   int           n0;
   int           n1;
   bit           ok;

   always #5 clk = ~clk;

   tm1638_ctrl #(.SCAN_PERIOD(SP), .READ_WIDTH(32)) dut (
      .i_Clk            (clk),
      .i_Rst            (rst),
      .i_Disp_Data      (disp_data),
      .i_Brightness     (bri),
      .i_Disp_On        (disp_on),
      .i_Update         (upd),
      .o_Busy           (busy),
      .o_Keys           (keys),
      .o_Keys_Valid     (keys_valid),
      .o_Keys_Changed   (keys_changed),
      .o_Spi_Data_Ready (spi_ready),
      .o_Spi_Data       (spi_data),
      .i_Spi_Busy       (spi_busy),
      .i_Spi_Rd_Data    (spi_rd)
   );

   // SPI engine model: logs each request, stays busy 20 cycles, then returns key_val
   always @(posedge clk) begin
      if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            spi_busy <= 1'b0;
            spi_rd   <= key_val;
         end
      end else if (spi_ready) begin
         if (logn < 512) log_q[logn] <= spi_data;
         logn     <= logn + 1;
         spi_busy <= 1'b1;
         m_cnt    <= 20;
      end
   end

   // Reference cycle count and scan-tick count since reset release
   always @(posedge clk) begin
      if (rst) begin
         cyc   <= 0;
         ntick <= 0;
      end else begin
         cyc <= cyc + 1;
         if ((cyc + 1) % SP == 0) ntick <= ntick + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [17:0] exp_dig(input int k, input logic [7:0] b);
      logic [7:0] a;
      a = 8'hC0 | 8'(k);
      return {2'b01, b, a};
   endfunction

   function automatic logic [17:0] log_at(input int i);
      if (i < 512) return log_q[i];
      return '0;
   endfunction

   task automatic wait_log(input int n, input string tag);
      int k = 0;
      while (logn < n && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (logn < n) check(tag, 32'(logn), 32'(n));
   endtask

   task automatic wait_valid(output bit seen);
      int k = 0;
      seen = 1'b0;
      while (!keys_valid && k < 500) begin
         @(negedge clk);
         k++;
      end
      seen = keys_valid;
   endtask

   task automatic wait_busy(input logic lvl, input string tag);
      int k = 0;
      while (busy !== lvl && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (busy !== lvl) check(tag, 32'(busy), 32'(lvl));
   endtask

   // Idle with no scan flag about to be set or just set
   task automatic wait_idle_window(input string tag);
      int k = 0;
      while (!(busy == 1'b0 && (cyc % SP) >= 1 && (cyc % SP) <= 90) && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (busy !== 1'b0) check(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 16; k++) begin
         old_img[8*k +: 8] = 8'(k);
         new_img[8*k +: 8] = 8'hA0 + 8'(k);
      end
      disp_data = old_img;
      bri       = 3'd3;
      disp_on   = 1'b1;
      upd       = 1'b0;
      key_val   = 32'h0000_0104;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(spi_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_keys", keys, 32'd0);
      check("rst_valid", 32'(keys_valid), 32'd0);
      check("rst_changed", 32'(keys_changed), 32'd0);
      check("rst_spi_data", 32'(spi_data), 32'd0);
      rst = 1'b0;

      // Power-up refresh, then the first scan
      base = logn;
      wait_log(base + 19, "p1_log_tmo");
      check("p1_mode", 32'(log_at(base)), 32'h00044);
      for (int k = 0; k < 16; k++)
         check("p1_digit", 32'(log_at(base + 1 + k)), 32'(exp_dig(k, 8'(k))));
      check("p1_ctrl", 32'(log_at(base + 17)), 32'h0008B);
      check("p1_scan", 32'(log_at(base + 18)), 32'h20042);
      wait_valid(ok);
      check("p1_valid_seen", 32'(ok), 32'd1);
      check("p1_keys", keys, 32'h0000_0104);
      check("p1_changed", 32'(keys_changed), 32'd1);
      @(negedge clk);
      check("p1_valid_pulse", 32'(keys_valid), 32'd0);
      check("p1_changed_pulse", 32'(keys_changed), 32'd0);

      // Same key word again: valid without changed
      wait_valid(ok);
      check("p2_valid_seen", 32'(ok), 32'd1);
      check("p2_keys", keys, 32'h0000_0104);
      check("p2_changed", 32'(keys_changed), 32'd0);
      @(negedge clk);

      // i_Update with new data while address 7 is in flight
      wait_idle_window("p3_idle_tmo");
      base = logn;
      upd = 1'b1;
      @(negedge clk);
      upd = 1'b0;
      wait_log(base + 9, "p3_addr7_tmo");
      disp_data = new_img;
      bri       = 3'd5;
      upd       = 1'b1;
      @(negedge clk);
      upd = 1'b0;
      wait_log(base + 37, "p3_log_tmo");
      for (int k = 8; k < 16; k++)
         check("p3_old_digit", 32'(log_at(base + 1 + k)), 32'(exp_dig(k, 8'(k))));
      check("p3_old_ctrl", 32'(log_at(base + 17)), 32'h0008B);
      check("p3_mode2", 32'(log_at(base + 18)), 32'h00044);
      for (int k = 0; k < 16; k++)
         check("p3_new_digit", 32'(log_at(base + 19 + k)), 32'(exp_dig(k, 8'hA0 + 8'(k))));
      check("p3_new_ctrl", 32'(log_at(base + 35)), 32'h0008D);
      check("p3_scan", 32'(log_at(base + 36)), 32'h20042);

      // Scan tick and i_Update on the same edge while idle
      begin
         int k = 0;
         while (!(busy == 1'b0 && (cyc % SP) == SP - 1) && k < 2000) begin
            @(negedge clk);
            k++;
         end
         check("p4_align", 32'(cyc % SP), 32'(SP - 1));
      end
      base = logn;
      upd = 1'b1;
      @(negedge clk);
      upd = 1'b0;
      wait_log(base + 18, "p4_refresh_tmo");
      check("p4_mode", 32'(log_at(base)), 32'h00044);
      check("p4_ctrl", 32'(log_at(base + 17)), 32'h0008D);
      wait_busy(1'b0, "p4_end_tmo");
      wait_busy(1'b1, "p4_scan_tmo");
      n0 = ntick;
      wait_log(base + 19, "p4_scan_log_tmo");
      check("p4_scan", 32'(log_at(base + 18)), 32'h20042);
      wait_valid(ok);
      check("p4_valid_seen", 32'(ok), 32'd1);
      n1 = ntick;
      @(negedge clk);
      check("p4_coalesce", 32'(busy), 32'(n1 > n0));

      // Reset while address 5 is in flight
      wait_idle_window("p5_idle_tmo");
      base = logn;
      upd = 1'b1;
      @(negedge clk);
      upd = 1'b0;
      wait_log(base + 7, "p5_addr5_tmo");
      check("p5_addr5", 32'(log_at(base + 6)), 32'(exp_dig(5, 8'hA5)));
      rst = 1'b1;
      @(negedge clk);
      check("p5_rst_ready", 32'(spi_ready), 32'd0);
      check("p5_rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      base = logn;
      wait_log(base + 18, "p5_restart_tmo");
      check("p5_restart_mode", 32'(log_at(base)), 32'h00044);
      check("p5_restart_d0", 32'(log_at(base + 1)), 32'(exp_dig(0, 8'hA0)));
      check("p5_restart_ctrl", 32'(log_at(base + 17)), 32'h0008D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tm1638_ctrl.md
Name: tm1638_ctrl

Overview:
Sequencer that drives the TM1638 SPI transaction engine (`spi`) on behalf of the board top level.
- Owns the command protocol: data-mode command, 16 display-RAM writes, display control, periodic key scan.
- Shares the single SPI engine between display refresh and key scanning by arbitrating two pending requests.
- Sits between user logic (digit/LED data, brightness, key consumer) and the `spi` instance.

Parameters:
- SCAN_PERIOD, 250000, i_Clk cycles between key-scan requests (10 ms at 25 MHz); legal range 2..2^24.
- READ_WIDTH, 32, width of the key-scan word returned by the SPI engine; fixed at 32 for TM1638.

Ports:
- i_Clk  in  1  clock
- i_Rst  in  1  synchronous reset, active-high
- i_Disp_Data  in  128  display RAM image; byte k = [8k+7:8k] goes to TM1638 address k (0..15)
- i_Brightness  in  3  pulse-width setting 0..7
- i_Disp_On  in  1  display enable
- i_Update  in  1  one-cycle strobe: request full refresh
- o_Busy  out  1  high while any SPI transaction sequence is in progress
- o_Keys  out  32  last key-scan word
- o_Keys_Valid  out  1  one-cycle pulse when o_Keys is updated
- o_Keys_Changed  out  1  one-cycle pulse, coincident with o_Keys_Valid, when the new word differs from the previous one
- o_Spi_Data_Ready  out  1  request strobe to the SPI engine
- o_Spi_Data  out  18  {rd_flag, has_data, data[7:0], cmd[7:0]}
- i_Spi_Busy  in  1  SPI engine busy
- i_Spi_Rd_Data  in  32  SPI engine read result

Behaviour:
- Reset: all outputs 0, o_Keys = 0, scan counter = 0, refresh_pending = 1 (power-up init), scan_pending = 0.
  - Reset mid-operation abandons the sequence immediately; o_Spi_Data_Ready drops the same edge.
- SPI transaction handshake sub-FSM, states T_IDLE, T_ISSUE, T_WAIT_ACK, T_WAIT_DONE:
  - T_ISSUE is entered only if i_Spi_Busy = 0.
  - In T_ISSUE, o_Spi_Data_Ready = 1 and o_Spi_Data is held stable for exactly one cycle (both registered).
  - T_WAIT_ACK: wait for i_Spi_Busy = 1 (expected on the next cycle).
  - T_WAIT_DONE: wait for i_Spi_Busy = 0, then report done.
  - o_Spi_Data keeps its value through T_WAIT_DONE.
- o_Spi_Data encoding:
  - [17] = 1 requests the 32-bit read phase after the command.
  - [16] = 1 sends the data byte [15:8] after the command.
- Top FSM states and transitions:
  - S_IDLE:
    - if refresh_pending -> S_MODE (clear refresh_pending, snapshot i_Disp_Data, i_Brightness, i_Disp_On into shadow registers);
    - else if scan_pending -> S_SCAN (clear scan_pending).
    - Refresh wins when both are pending.
  - S_MODE: one transaction, o_Spi_Data = {0,0,8'h00,8'h44} (write, fixed address) -> S_DIGITS with addr = 0.
  - S_DIGITS: transaction {0,1,shadow byte[addr],8'hC0|addr}.
    - addr increments on done; after addr = 15 -> S_CTRL.
    - addr is 4 bits; no wrap is permitted beyond 15.
  - S_CTRL: transaction {0,0,8'h00,8'h80|{on,brightness}} -> S_IDLE.
  - S_SCAN: transaction {1,0,8'h00,8'h42}.
    - On done: o_Keys <= i_Spi_Rd_Data.
    - Pulse o_Keys_Valid, and o_Keys_Changed if the value differs from the previous o_Keys.
    - -> S_IDLE.
- o_Busy = (top state != S_IDLE).
- Full refresh = 18 transactions. Each transaction adds 3 controller cycles plus SPI engine time.
- Scan timer:
  - Free-running modulo-SCAN_PERIOD counter.
  - On reaching SCAN_PERIOD-1 it wraps to 0 and sets scan_pending.
  - A set flag stays set; missed ticks coalesce into one scan and never queue twice.
- i_Update:
  - Sets refresh_pending in any state, including during a refresh. The new request then causes exactly one more refresh afterwards.
  - Inputs changing mid-refresh do not affect the current refresh (shadow registers).
- Simultaneous i_Update and a scan tick in S_IDLE: both flags set; refresh runs first, then scan.

Decomposition:
- Package tm1638_pkg:
  - command constants CMD_DATA_FIXED = 8'h44, CMD_READ_KEYS = 8'h42, CMD_ADDR_BASE = 8'hC0, CMD_DISP_CTRL = 8'h80;
  - bit indices SPI_RD_FLAG = 17, SPI_HAS_DATA = 16;
  - top-state enum.
- One sub-module, tm1638_spi_txn, implements the handshake FSM:
  - inputs start and payload[17:0];
  - outputs done pulse and the SPI request signals.

Test Plan:
- Reset release, SPI model busy 20 cycles per transaction, i_Disp_Data = 128'h0F0E..00, brightness 3, on 1 -> 18 requests in order: 0x00044; 0x100C0 .. 0x10FCF with data bytes 00..0F; final 0x0008B.
- After the refresh, SCAN_PERIOD = 100, model returns 32'h0000_0104 -> request 0x20042; o_Keys = 32'h104 with o_Keys_Valid and o_Keys_Changed high for one cycle.
- Two consecutive scans returning the same value -> o_Keys_Valid pulses both times; o_Keys_Changed pulses only on the first.
- i_Update asserted while address 7 is in flight, i_Disp_Data changed at the same time -> current refresh sends the old bytes 8..15, then exactly one further refresh with the new bytes.
- Scan tick and i_Update in the same cycle in S_IDLE -> 18 refresh transactions, then one 0x20042; no second scan unless another tick elapses.
- i_Rst pulsed during S_DIGITS at addr 5 -> o_Spi_Data_Ready = 0 and o_Busy = 0 next cycle; new init sequence restarts from 0x00044.
